// File: rtl/mem_burst_responder.sv
// mem_burst_responder: block-read / single-word-write memory responder for a
// cache fill engine. Reads return an 8-beat burst of 16-bit words starting at
// the 16-byte aligned block, LATENCY cycles after the request is accepted.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE while rst is low.
// Response beats have no backpressure: rsp_valid is high for exactly eight
// consecutive cycles per read. rsp_last marks the eighth beat.
module mem_burst_responder #(
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int BURST_LEN  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_addr,
    output logic        rsp_last,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    // The wait counter counts remaining WAIT cycles; zero means the next edge
    // starts beat 0, so a load of LATENCY-1 gives LATENCY edges to the first beat.
    localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  beat_q, beat_d;
    logic [15:0] base_q, base_d;

    logic        wr_en;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data_q;

    logic [15:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Next-state, counter and memory-port control for the request/burst FSM.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_d     = beat_q;
        base_d     = base_q;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = base_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_wr) begin
                        wr_en = 1'b1;
                    end else begin
                        // Low address bits ignored: no critical-word-first.
                        base_d     = {req_addr[15:4], 4'b0000};
                        wait_cnt_d = LAT_M1;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = BURST;
                    beat_d  = 3'd0;
                    rd_en   = 1'b1;
                    rd_addr = base_q;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = 3'd0;
                end else begin
                    beat_d  = beat_q + 3'd1;
                    rd_en   = 1'b1;
                    rd_addr = base_q + {12'b0, beat_q + 3'd1, 1'b0};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            beat_q     <= 3'd0;
            base_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
        end
    end

    // Backing store: one write port, one registered read port; never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[req_addr[ADDR_WIDTH:1]] <= req_wdata;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr[ADDR_WIDTH:1]];
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == BURST);
    assign rsp_last  = (state_q == BURST) && (beat_q == LAST_BEAT);
    assign rsp_addr  = base_q + {12'b0, beat_q, 1'b0};
    assign rsp_data  = rd_data_q;
    assign dbg_state = state_q;

    // Byte-select bit and aliased high bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{req_addr[0], rd_addr};

endmodule

// File: tb/tb_mem_burst_responder.sv
module tb_mem_burst_responder;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;
  localparam int AW   = 13;
  localparam int EW   = 65; // {cycle[31:0], last, addr[15:0], data[15:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // DUT 0: default build (LATENCY=4)
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_last;
  logic [15:0] rsp_data, rsp_addr;
  logic [1:0]  dbg_state;

  // DUT 1: LATENCY=1 build
  logic        r1_valid = 1'b0, r1_wr = 1'b0;
  logic [15:0] r1_addr = '0, r1_wdata = '0;
  logic        r1_ready, s1_valid, s1_last;
  logic [15:0] s1_data, s1_addr;
  logic [1:0]  dbg1_state;

  mem_burst_responder #(.LATENCY(LAT0), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_last(rsp_last), .dbg_state(dbg_state)
  );

  mem_burst_responder #(.LATENCY(LAT1), .ADDR_WIDTH(AW)) dut1 (
    .clk(clk), .rst(rst), .req_valid(r1_valid), .req_wr(r1_wr),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .req_ready(r1_ready),
    .rsp_valid(s1_valid), .rsp_data(s1_data), .rsp_addr(s1_addr),
    .rsp_last(s1_last), .dbg_state(dbg1_state)
  );

  // Reference memories and expected-beat queues
  logic [15:0] model0 [0:(1<<AW)-1];
  logic [15:0] model1 [0:(1<<AW)-1];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp1_q[$];

  // Scoreboard monitor, DUT 0
  logic m0_v;
  logic [EW-1:0] m0_e;
  always @(negedge clk) if (mon_en) begin
    m0_v = (exp_q.size() > 0) && (exp_q[0][64:33] == 32'(cyc));
    checks++;
    if (rsp_valid !== m0_v) begin
      errors++;
      $display("FAIL d0_rsp_valid cyc=%0d got %b exp %b", cyc, rsp_valid, m0_v);
    end
    if (m0_v) begin
      m0_e = exp_q.pop_front();
      checks++;
      if ({rsp_last, rsp_addr, rsp_data} !== m0_e[32:0]) begin
        errors++;
        $display("FAIL d0_beat cyc=%0d got last=%b addr=%h data=%h exp last=%b addr=%h data=%h",
                 cyc, rsp_last, rsp_addr, rsp_data, m0_e[32], m0_e[31:16], m0_e[15:0]);
      end
    end else begin
      checks++;
      if (rsp_last !== 1'b0) begin
        errors++;
        $display("FAIL d0_last_idle cyc=%0d got %b exp 0", cyc, rsp_last);
      end
    end
    while (exp_q.size() > 0 && exp_q[0][64:33] <= 32'(cyc)) void'(exp_q.pop_front());
  end

  // Scoreboard monitor, DUT 1
  logic m1_v;
  logic [EW-1:0] m1_e;
  always @(negedge clk) if (mon_en) begin
    m1_v = (exp1_q.size() > 0) && (exp1_q[0][64:33] == 32'(cyc));
    checks++;
    if (s1_valid !== m1_v) begin
      errors++;
      $display("FAIL d1_rsp_valid cyc=%0d got %b exp %b", cyc, s1_valid, m1_v);
    end
    if (m1_v) begin
      m1_e = exp1_q.pop_front();
      checks++;
      if ({s1_last, s1_addr, s1_data} !== m1_e[32:0]) begin
        errors++;
        $display("FAIL d1_beat cyc=%0d got last=%b addr=%h data=%h exp last=%b addr=%h data=%h",
                 cyc, s1_last, s1_addr, s1_data, m1_e[32], m1_e[31:16], m1_e[15:0]);
      end
    end
    while (exp1_q.size() > 0 && exp1_q[0][64:33] <= 32'(cyc)) void'(exp1_q.pop_front());
  end

  // Driver: present one request, wait (bounded) for acceptance, update model.
  task automatic send_req(input bit sel, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output int k);
    logic rdy;
    bit acc;
    logic [15:0] base, a, d;
    acc = 0;
    k = -1;
    @(posedge clk); #1;
    if (sel) begin r1_valid = 1; r1_wr = wr; r1_addr = addr; r1_wdata = wdata; end
    else     begin req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata; end
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      rdy = sel ? r1_ready : req_ready;
      @(posedge clk); #1;
      if (rdy === 1'b1) begin acc = 1; k = cyc; break; end
    end
    if (sel) r1_valid = 0; else req_valid = 0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout sel=%0d addr=%h got no accept exp accept", sel, addr);
    end else if (wr) begin
      if (sel) model1[addr[AW:1]] = wdata; else model0[addr[AW:1]] = wdata;
    end else begin
      base = {addr[15:4], 4'b0000};
      for (int i = 0; i < 8; i++) begin
        a = base + 16'(2 * i);
        d = sel ? model1[a[AW:1]] : model0[a[AW:1]];
        if (sel) exp1_q.push_back({32'(k + LAT1 + i), (i == 7), a, d});
        else     exp_q.push_back({32'(k + LAT0 + i), (i == 7), a, d});
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (exp_q.size() > 0 || exp1_q.size() > 0); t++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending beats exp 0/0", exp_q.size(), exp1_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req_valid = 1; req_wr = 0; req_addr = 16'h1000;
    r1_valid = 1; r1_wr = 0; r1_addr = 16'h1000;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || r1_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got ready=%b valid=%b ready1=%b exp 0 0 0", req_ready, rsp_valid, r1_ready);
      end
    end
    @(posedge clk); #1;
    rst = 0; req_valid = 0; r1_valid = 0;
    mon_en = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || r1_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got ready=%b ready1=%b exp 1 1", req_ready, r1_ready);
    end
    repeat (6) @(negedge clk); // monitors confirm no beats
  endtask

  task automatic test_write_read();
    int k;
    for (int i = 0; i < 8; i++) send_req(0, 1, 16'h1000 + 16'(2 * i), 16'hA000 + 16'(i), k);
    send_req(0, 0, 16'h1006, 16'h0000, k);
    drain();
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    send_req(0, 0, 16'h1000, 16'h0000, k1);
    send_req(0, 0, 16'h1008, 16'h0000, k2);
    checks++;
    if (k2 - k1 != LAT0 + 9) begin
      errors++;
      $display("FAIL busy_accept_gap got %0d exp %0d", k2 - k1, LAT0 + 9);
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    int k, cut;
    send_req(0, 0, 16'h1000, 16'h0000, k);
    while (cyc < k + LAT0 + 3) begin @(posedge clk); #1; end
    rst = 1;
    cut = k + LAT0 + 4;
    while (exp_q.size() > 0 && exp_q[$][64:33] >= 32'(cut)) void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_burst got ready=%b valid=%b exp 1 0", req_ready, rsp_valid);
    end
    repeat (5) @(negedge clk);
    send_req(0, 0, 16'h100A, 16'h0000, k);
    drain();
  endtask

  task automatic test_alias();
    int k;
    for (int i = 0; i < 8; i++) send_req(0, 1, 16'h0010 + 16'(2 * i), 16'h5500 + 16'(i), k);
    send_req(0, 1, 16'h4010, 16'h1234, k);
    send_req(0, 0, 16'h0010, 16'h0000, k);
    checks++;
    if (exp_q.size() == 0 || exp_q[0][31:0] !== 32'h0010_1234) begin
      errors++;
      $display("FAIL alias_model got %h exp 00101234", exp_q.size() ? exp_q[0][31:0] : 32'h0);
    end
    drain();
  endtask

  task automatic test_random();
    int k;
    logic [15:0] blk;
    for (int n = 0; n < 3; n++) begin
      blk = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFF0;
      for (int i = 0; i < 8; i++)
        send_req(0, 1, blk + 16'(2 * i) + 16'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)), k);
      send_req(0, 0, blk | 16'($urandom_range(0, 15)), 16'h0000, k);
    end
    drain();
  endtask

  task automatic test_latency1();
    int k1, k2;
    for (int i = 0; i < 8; i++) send_req(1, 1, 16'h2200 + 16'(2 * i), 16'hC0DE + 16'(i * 3), k1);
    send_req(1, 0, 16'h220E, 16'h0000, k1);
    send_req(1, 0, 16'h2200, 16'h0000, k2);
    checks++;
    if (k2 - k1 != LAT1 + 9) begin
      errors++;
      $display("FAIL lat1_accept_gap got %0d exp %0d", k2 - k1, LAT1 + 9);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_burst();
    test_alias();
    test_random();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
